// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - valid/ready channel carrying a flat packed payload
interface branch_unit_if #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - control-transfer execution unit with 2-entry skid output
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_unit_if.slave     decoded,
  branch_unit_if.master    result,
  input  logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] misp_cnt
);

  localparam logic [2:0] OP_AUIPC  = 3'd0;
  localparam logic [2:0] OP_JAL    = 3'd1;
  localparam logic [2:0] OP_JALR   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;

  // Payload layouts, MSB first; decoded.data is 5*XLEN+13 bits, result.data 3*XLEN+12.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [2:0]      funct3;
    logic [2:0]      op;
    logic [4:0]      rd;
    logic            rvc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } dec_t;

  typedef struct packed {
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_val;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            ret_valid;
    logic            ex_valid;
    logic [3:0]      ex;
    logic [XLEN-1:0] ex_tval;
  } res_t;

  dec_t            issue;
  res_t            nres;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] rel;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            cond;
  logic            f3_bad;
  logic            is_ctl;
  logic            illegal;
  logic            taken;
  logic            misaligned;
  logic            misp;
  logic            count_br;
  logic            count_misp;

  assign issue = decoded.data;

  always_comb begin
    link        = issue.pc + ((C_EXT != 0 && issue.rvc) ? XLEN'(2) : XLEN'(4));
    rel         = issue.pc + issue.imm;
    jalr_target = (issue.rs1_val + issue.imm) & ~XLEN'(1);
    eq          = issue.rs1_val == issue.rs2_val;
    lt          = $signed(issue.rs1_val) < $signed(issue.rs2_val);
    ltu         = issue.rs1_val < issue.rs2_val;

    cond   = 1'b0;
    f3_bad = 1'b0;
    case (issue.funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: f3_bad = 1'b1;
    endcase

    is_ctl  = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    target  = rel;
    case (issue.op)
      OP_AUIPC:  ;
      OP_JAL:    begin is_ctl = 1'b1; taken = 1'b1; end
      OP_JALR:   begin is_ctl = 1'b1; taken = 1'b1; target = jalr_target; end
      OP_BRANCH: begin is_ctl = 1'b1; taken = cond; illegal = f3_bad; end
      default:   illegal = 1'b1;
    endcase

    misaligned = is_ctl && taken && (C_EXT == 0) && target[1];
    misp       = (taken != issue.pred_taken) || (taken && target != issue.pred_target);

    // Exceptions suppress redirect and writeback; illegal outranks misalignment.
    nres = '0;
    if (illegal) begin
      nres.ex_valid = 1'b1;
      nres.ex       = 4'd2;
    end else if (misaligned) begin
      nres.ex_valid = 1'b1;
      nres.ex_tval  = target;
    end else if (is_ctl) begin
      nres.br_valid  = misp;
      nres.br_target = taken ? target : link;
      if (issue.op != OP_BRANCH) begin
        nres.rd_idx = issue.rd;
        nres.rd_val = link;
      end
    end else begin
      nres.rd_idx = issue.rd;
      nres.rd_val = rel;
    end

    count_br   = is_ctl && !illegal && !misaligned;
    count_misp = count_br && misp;
  end

  logic main_valid;
  logic skid_valid;
  res_t main_q;
  res_t skid_q;
  logic accept;
  logic drain;

  assign accept        = decoded.valid && !skid_valid && !flush;
  assign drain         = main_valid && result.ready;
  assign decoded.ready = !skid_valid;
  assign result.valid  = main_valid;
  assign result.data   = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      br_cnt     <= '0;
      misp_cnt   <= '0;
    end else begin
      if (accept && count_br)   br_cnt   <= br_cnt + 1'b1;
      if (accept && count_misp) misp_cnt <= misp_cnt + 1'b1;

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || drain) begin
        // Skid is only ever occupied behind a full main, so it refills main first.
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= accept;
          if (accept) main_q <= nres;
        end
      end else if (accept) begin
        skid_q     <= nres;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised control-transfer execution unit, successor to the combinational PC-relative unit. Resolves AUIPC, JAL, JALR and conditional branches against the front-end prediction, and raises misaligned-target and illegal-instruction exceptions. Sits between the issue stage (`decoupled.in`) and writeback/redirect (`decoupled.out`). Adds a registered 2-entry skid output, pipeline flush, and saturation-free branch/mispredict performance counters.

## Interface
- `XLEN`, default 32: data and address width.
- `C_EXT`, default 0: 1 allows 2-byte-aligned targets and 2-byte link for compressed instructions.
- `CNT_W`, default 32: width of each performance counter.
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `decoded`  decoupled.in  -  issue payload: `pc`, `imm`, `rs1_val`, `rs2_val` (`XLEN` each), `funct3`, `op`, `rd`, `rvc`, `pred_taken`, `pred_target` (`XLEN`).
- `result`  decoupled.out  -  `exec_result` payload: `rd_idx`, `rd_val`, `br_valid`, `br_target`, `ret_valid`, `ex_valid`, `ex`, `ex_tval`.
- `flush`  in  1  discard every held and incoming entry.
- `br_cnt`  out  `CNT_W`  resolved control transfers.
- `misp_cnt`  out  `CNT_W`  mispredicted control transfers.

## Operation
- `link = pc + ((C_EXT && rvc) ? 2 : 4)`.
  - `rvc` is ignored when `C_EXT=0`.
- `rel = pc + imm`.
- JALR target: `(rs1_val + imm) & ~1`.
- Branch conditions by `funct3`:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011 are illegal.
- Per op:
  - AUIPC: `rd_val = rel`, never taken, no prediction check.
  - JAL: taken, target `rel`, `rd_val = link`.
  - JALR: taken, target per JALR rule above, `rd_val = link`.
  - BRANCH: taken per condition, target `rel`, `rd_idx` forced to 0.
- Misprediction, checked for JAL, JALR and BRANCH only:
  - `misp = (taken != pred_taken) || (taken && target != pred_target)`.
  - `br_valid = misp`.
  - `br_target = taken ? target : link`.
- Misaligned target: taken, `C_EXT=0` and `target[1]=1`.
  - `ex_valid=1`, `ex=0` (instruction address misaligned), `ex_tval=target`.
  - `br_valid=0`, `rd_idx=0`.
- Illegal (unknown `op` or illegal `funct3`):
  - `ex_valid=1`, `ex=2`, `ex_tval=0`, `br_valid=0`, `rd_idx=0`.
- `ret_valid` is always 0.
- Counters, updated on input handshake only:
  - `br_cnt` increments for accepted JAL, JALR and BRANCH without exception.
  - `misp_cnt` increments when such an op also has `misp=1`.
  - Both wrap modulo 2^`CNT_W`.
- Output buffer: main register plus one skid register.
  - `decoded.ready = !skid_valid`.
  - Accept when `decoded.valid && decoded.ready && !flush`.
  - Accepted result goes to main if main is empty or draining this cycle, otherwise to skid.
  - On a drain, skid moves to main.
  - Order is strictly FIFO.

## Timing
- Latency: accept in cycle N, result visible with `result.valid=1` in cycle N+1.
- Throughput: 1 per cycle while `result.ready=1`.
- Backpressure:
  - With `result.ready=0`, one more entry is absorbed into the skid.
  - `decoded.ready` then drops in the following cycle.
- `result.data` is stable while `result.valid && !result.ready`.
- `flush`:
  - Clears main and skid at the next edge.
  - Input in the same cycle is dropped and not counted.
  - `result.valid=0` in the next cycle.
  - A drain in the flush cycle still completes.
- Reset (`rst` sampled high at an edge):
  - `result.valid=0`, all `result.data` fields 0, `decoded.ready=1` next cycle, counters 0.
  - `rst` mid-operation discards held entries exactly like `flush`.
  - `rst` has priority over `flush` and the handshake.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, `pred_taken=0`:
  - Next cycle `br_valid=1`, `br_target=0x120`.
  - `br_cnt=1`, `misp_cnt=1`.
- BNE, rs1=rs2, `pred_taken=0`:
  - `br_valid=0`, `br_target=0x104`.
  - `br_cnt` increments, `misp_cnt` unchanged.
- JALR, rs1=0x203, imm=0, `C_EXT=0`:
  - `ex_valid=1`, `ex=0`, `ex_tval=0x202`, `rd_idx=0`, no count.
- Same JALR with `C_EXT=1`, `rvc=1`:
  - Target 0x202 accepted, `rd_val=pc+2`.
- Backpressure:
  - Issue 3 back-to-back AUIPCs with `result.ready=0`.
  - `decoded.ready` drops after the 2nd.
  - Releasing `ready` yields all 3 in order.
- Flush and reset:
  - Flush with 2 held entries: `result.valid=0` next cycle, counters unchanged.
  - Reset with `CNT_W=4` after 16 branches: counters were 0 (wrapped); after reset all outputs 0.
